// File: rtl/sync_memory.sv
// Single-port synchronous RAM with a valid/ready request port.
// One read or write per clock; read data is registered and appears one cycle after acceptance.
module sync_memory #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata
);

  logic                  ready_q, ready_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0]      rd_word;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH-1:0]      word_we;
  logic                  accept;

  assign accept = valid && ready_q;

  // Out-of-range addresses match no word, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = accept && wr_rd && (addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = word_we[i] ? wdata : mem_q[i];
    end
  end

  // Out-of-range reads fall through to the zero default.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        rd_word = mem_q[i];
      end
    end
  end

  always_comb begin
    ready_d = 1'b1;
    rdata_d = rdata_q;
    if (accept && !wr_rd) begin
      rdata_d = rd_word;
    end
  end

  // Storage is cleared by reset, so it lives in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_sync_memory.sv
// Scoreboard bench: a full-range RAM and a 12-word RAM share one stimulus stream.
// A behavioural model queues expected read data; a negedge monitor pops and compares.
module tb_sync_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       wr_rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ready16, ready12;
  logic [7:0] rdata16, rdata12;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_memory #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd),
    .addr(addr), .wdata(wdata), .ready(ready16), .rdata(rdata16)
  );

  sync_memory #(.WIDTH(8), .DEPTH(12), .ADDR_WIDTH(4)) dut12 (
    .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd),
    .addr(addr), .wdata(wdata), .ready(ready12), .rdata(rdata12)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d16;
    logic [7:0] d12;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m16[16];
  logic [7:0] m12[12];
  logic       mdl_ready = 1'b0;
  logic       started   = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endtask

  // Reference model: memory as plain arrays, updated on every edge.
  always @(posedge clk) begin
    exp_t e;
    started = 1'b1;
    if (rst) begin
      foreach (m16[i]) m16[i] = 8'h00;
      foreach (m12[i]) m12[i] = 8'h00;
      mdl_ready = 1'b0;
    end else begin
      if (valid && mdl_ready) begin
        if (wr_rd) begin
          m16[addr] = wdata;
          if (int'(addr) < 12) m12[addr] = wdata;
        end else begin
          e.a   = addr;
          e.d16 = m16[addr];
          e.d12 = (int'(addr) < 12) ? m12[addr] : 8'h00;
          exp_q.push_back(e);
        end
      end
      mdl_ready = 1'b1;
    end
  end

  // Monitor: ready every cycle, read data whenever a response is due.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("ready16", {7'd0, ready16}, {7'd0, mdl_ready});
      chk("ready12", {7'd0, ready12}, {7'd0, mdl_ready});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("rd16[%0d]", e.a), rdata16, e.d16);
        chk($sformatf("rd12[%0d]", e.a), rdata12, e.d12);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic w,
                      input logic [3:0] a, input logic [7:0] d);
    rst   = r;
    valid = v;
    wr_rd = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two edges, then a write on the release edge that must be ignored.
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    chk("rst_rdata16", rdata16, 8'h00);
    chk("rst_rdata12", rdata12, 8'h00);
    chk("rst_ready", {7'd0, ready16}, 8'h00);
    step(1'b0, 1'b1, 1'b1, 4'd3, 8'hEE);
    chk("ready_up", {7'd0, ready16}, 8'h01);

    // Single write then read.
    step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);

    // Full sweep, back to back.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'(i + 16));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'($urandom));

    // Idle hold with random don't-care inputs.
    step(1'b0, 1'b1, 1'b1, 4'd9, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 4'd9, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
      chk("hold16", rdata16, 8'h5A);
      chk("hold12", rdata12, 8'h5A);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);

    // Reset in the middle of operation overrides a concurrent write.
    step(1'b0, 1'b1, 1'b1, 4'd7, 8'h3C);
    step(1'b1, 1'b1, 1'b1, 4'd7, 8'hFF);
    step(1'b0, 1'b1, 1'b1, 4'd7, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 4'd7, 8'h00);

    // Out-of-range access on the 12-word instance.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'(8'hC0 + i));
    step(1'b0, 1'b1, 1'b1, 4'd14, 8'h77);
    step(1'b0, 1'b1, 1'b0, 4'd14, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
           1'($urandom), 4'($urandom), 8'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
